uart_coord_rx: RTL and testbench

UART_COORD_RX -- requirements
Module: uart_coord_rx

---
 rtl/uart_coord_pkg.sv | 24 ++
 rtl/uart_byte_rx.sv | 121 ++++++++++++
 rtl/uart_coord_rx.sv | 119 +++++++++++
 tb/tb_uart_coord_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_coord_pkg.sv
// Shared definitions for the UART coordinate receiver: byte FSM states, byte field
// positions and the bit-period helper.
package uart_coord_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } rx_state_e;

    localparam int unsigned TAG_MSB   = 7;
    localparam int unsigned TAG_LSB   = 4;
    localparam int unsigned DIG_MSB   = 3;
    localparam int unsigned DIG_LSB   = 0;
    localparam int unsigned MAX_DIGIT = 9;
    localparam int unsigned MAX_SLOTS = 15;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: two-flop input sync, bit-period counter, byte FSM, frame error.
// Emits a one-cycle byte_valid the cycle after a good stop-bit sample.
module uart_byte_rx
    import uart_coord_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       rx_i,
    input  logic       rx_en,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV + 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             half_end, full_end;

    assign half_end = (cnt_q == CNT_W'(HALF - 1));
    assign full_end = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            StIdle: begin
                bit_d = 3'd0;
                if (rx_en && prev_q && !sync2_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (half_end) begin
                    // Line back high at mid-start means a glitch, not a start bit.
                    state_d = sync2_q ? StIdle : StData;
                end
            end
            StData: begin
                if (full_end) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (full_end) begin
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                if (sync2_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!rx_en && state_q != StIdle) begin
            state_d = StIdle;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
        end
        if (state_d != state_q || state_q == StIdle) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_data  = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_coord_rx.sv
// Tagged-digit coordinate receiver: parses (tag,digit) bytes into NCH*NDIG decimal
// slots and publishes saturated binary channels once a whole frame has arrived.
module uart_coord_rx
    import uart_coord_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned NCH    = 2,
    parameter int unsigned NDIG   = 3,
    parameter int unsigned OUT_W  = 10
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 rx_i,
    input  logic                 rx_en,
    output logic [NCH*OUT_W-1:0] coord_o,
    output logic                 coord_valid,
    output logic                 frame_err,
    output logic                 proto_err
);

    localparam int unsigned NDW = NCH * NDIG;
    localparam logic [63:0] SAT = (64'd1 << OUT_W) - 64'd1;

    if (NDW > MAX_SLOTS || NDW == 0) begin : g_cfg_check
        $error("uart_coord_rx: NCH*NDIG must be in 1..15");
    end

    logic [7:0]           byte_data;
    logic                 byte_valid;
    logic [3:0]           tag, digit;
    logic [3:0]           dig_q [NDW];
    logic [3:0]           dig_d [NDW];
    logic [3:0]           k_q, k_d;
    logic [NCH*OUT_W-1:0] coord_q, coord_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;

    uart_byte_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_byte_rx (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .rx_i      (rx_i),
        .rx_en     (rx_en),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign tag   = byte_data[TAG_MSB:TAG_LSB];
    assign digit = byte_data[DIG_MSB:DIG_LSB];

    always_comb begin
        logic [63:0] acc;
        acc     = '0;
        dig_d   = dig_q;
        k_d     = k_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        coord_d = coord_q;
        if (byte_valid) begin
            if (digit <= 4'(MAX_DIGIT) && tag == k_q + 4'd1) begin
                for (int i = 0; i < NDW; i++) begin
                    if (k_q == 4'(i)) begin
                        dig_d[i] = digit;
                    end
                end
                if (k_q == 4'(NDW - 1)) begin
                    k_d     = 4'd0;
                    valid_d = 1'b1;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end else if (digit <= 4'(MAX_DIGIT) && tag == 4'd1) begin
                // A fresh first tag mid-frame resynchronises rather than erroring.
                dig_d[0] = digit;
                k_d      = 4'd1;
            end else begin
                perr_d = 1'b1;
                k_d    = 4'd0;
            end
        end

        if (valid_d) begin
            for (int c = 0; c < NCH; c++) begin
                acc = '0;
                for (int i = 0; i < NDIG; i++) begin
                    acc = acc * 64'd10 + 64'(dig_d[c*NDIG+i]);
                end
                coord_d[c*OUT_W +: OUT_W] = (acc > SAT) ? OUT_W'(SAT) : OUT_W'(acc);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < NDW; i++) begin
                dig_q[i] <= 4'd0;
            end
            k_q     <= 4'd0;
            coord_q <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            dig_q   <= dig_d;
            k_q     <= k_d;
            coord_q <= coord_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
        end
    end

    assign coord_o     = coord_q;
    assign coord_valid = valid_q;
    assign proto_err   = perr_q;

endmodule

// File: tb/tb_uart_coord_rx.sv
// Self-checking bench for uart_coord_rx: a frame-level model predicts decoded coordinates
// and error pulses; a per-cycle monitor compares the DUT against it.
module tb_uart_coord_rx;

    localparam int unsigned CLK_HZ = 3200000;
    localparam int unsigned BAUD   = 100000;
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx = 1'b1;
    logic        rx4 = 1'b1;
    logic        rx_en = 1'b1;
    logic [19:0] coord, coord4;
    logic        coord_valid, frame_err, proto_err;
    logic        coord_valid4, frame_err4, proto_err4;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_coord_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NCH(2), .NDIG(3), .OUT_W(10)) dut (
        .CLK        (clk),
        .RSTn       (rst_n),
        .rx_i       (rx),
        .rx_en      (rx_en),
        .coord_o    (coord),
        .coord_valid(coord_valid),
        .frame_err  (frame_err),
        .proto_err  (proto_err)
    );

    uart_coord_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NCH(2), .NDIG(4), .OUT_W(10)) dut4 (
        .CLK        (clk),
        .RSTn       (rst_n),
        .rx_i       (rx4),
        .rx_en      (rx_en),
        .coord_o    (coord4),
        .coord_valid(coord_valid4),
        .frame_err  (frame_err4),
        .proto_err  (proto_err4)
    );

    // Frame-level model of the 2x3 instance.
    int          m_k = 0;
    int          m_dig [6];
    logic [19:0] exp_q [$];
    int          exp_perr = 0, exp_ferr = 0;
    int          seen_perr = 0, seen_ferr = 0, seen_valid = 0;
    logic [19:0] held = 20'd0;
    int          seen_valid4 = 0, seen_err4 = 0;
    logic [19:0] last4 = 20'd0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input logic stop_bit);
        int tag, dg, ch0, ch1;
        if (!stop_bit) begin
            exp_ferr++;
            return;
        end
        tag = int'(b[7:4]);
        dg  = int'(b[3:0]);
        if (dg <= 9 && tag == m_k + 1) begin
            m_dig[m_k] = dg;
            m_k++;
            if (m_k == 6) begin
                m_k = 0;
                ch0 = m_dig[0] * 100 + m_dig[1] * 10 + m_dig[2];
                ch1 = m_dig[3] * 100 + m_dig[4] * 10 + m_dig[5];
                if (ch0 > 1023) ch0 = 1023;
                if (ch1 > 1023) ch1 = 1023;
                exp_q.push_back({10'(ch1), 10'(ch0)});
            end
        end else if (dg <= 9 && tag == 1) begin
            m_dig[0] = dg;
            m_k = 1;
        end else begin
            exp_perr++;
            m_k = 0;
        end
    endtask

    task automatic drive(input bit to4, input logic v);
        if (to4) rx4 = v;
        else rx = v;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit to4);
        logic [9:0] fr;
        if (!to4) model_byte(b, stop_bit);
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(to4, fr[i]);
            repeat (DIV) @(negedge clk);
        end
        drive(to4, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, b5);
        send_byte(b0, 1'b1, 1'b0);
        send_byte(b1, 1'b1, 1'b0);
        send_byte(b2, 1'b1, 1'b0);
        send_byte(b3, 1'b1, 1'b0);
        send_byte(b4, 1'b1, 1'b0);
        send_byte(b5, 1'b1, 1'b0);
    endtask

    task automatic settle_and_check(input string tag);
        repeat (2 * DIV) @(negedge clk);
        check({tag, "_perr"}, seen_perr, exp_perr);
        check({tag, "_ferr"}, seen_ferr, exp_ferr);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_coord", int'(coord === 20'd0), 1);
            check("reset_pulses", int'({coord_valid, proto_err, frame_err} === 3'b000), 1);
            held = 20'd0;
        end else begin
            if (coord_valid) begin
                seen_valid++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    check("coord_frame", int'(coord), int'(exp_q.pop_front()));
                end
                held = coord;
            end else begin
                check("coord_hold", int'(coord), int'(held));
            end
            if (proto_err) seen_perr++;
            if (frame_err) seen_ferr++;
            if (coord_valid4) begin
                seen_valid4++;
                last4 = coord4;
            end
            if (proto_err4 || frame_err4) seen_err4++;
        end
    end

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        for (int i = 0; i < 6; i++) m_dig[i] = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Four-digit channels: 1234 saturates, 0001 passes through.
        send_byte(8'h11, 1'b1, 1'b1); send_byte(8'h22, 1'b1, 1'b1);
        send_byte(8'h33, 1'b1, 1'b1); send_byte(8'h44, 1'b1, 1'b1);
        send_byte(8'h50, 1'b1, 1'b1); send_byte(8'h60, 1'b1, 1'b1);
        send_byte(8'h70, 1'b1, 1'b1); send_byte(8'h81, 1'b1, 1'b1);
        repeat (2 * DIV) @(negedge clk);
        check("ndig4_valid_count", seen_valid4, 1);
        check("ndig4_ch0_sat", int'(last4[9:0]), 1023);
        check("ndig4_ch1", int'(last4[19:10]), 1);
        check("ndig4_errors", seen_err4, 0);

        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
        settle_and_check("basic");
        check("basic_ch0", int'(held[9:0]), 123);
        check("basic_ch1", int'(held[19:10]), 456);
        check("basic_valid_count", seen_valid, 1);

        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        settle_and_check("tag_skip");
        check("tag_skip_perr_once", seen_perr, 1);
        check("tag_skip_hold", int'(held[9:0]), 123);
        send_frame(8'h19, 8'h29, 8'h39, 8'h40, 8'h50, 8'h67);
        settle_and_check("nines");
        check("nines_ch0", int'(held[9:0]), 999);
        check("nines_ch1", int'(held[19:10]), 7);

        send_byte(8'h1A, 1'b1, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        settle_and_check("bad_digit_stop");
        check("frame_err_once", seen_ferr, 1);
        check("bad_digit_perrs", seen_perr, 3);

        // Restart on tag 1 mid-frame.
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_frame(8'h13, 8'h24, 8'h35, 8'h46, 8'h57, 8'h68);
        settle_and_check("restart");
        check("restart_ch0", int'(held[9:0]), 345);
        check("restart_ch1", int'(held[19:10]), 678);

        // Short idle glitch, then a byte cut off by rx_en.
        v0 = seen_valid;
        rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        rx = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        rx_en = 1'b0;
        rx = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        rx_en = 1'b1;
        repeat (4) @(negedge clk);
        settle_and_check("glitch_abort");
        check("glitch_abort_no_valid", seen_valid, v0);
        send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60);
        settle_and_check("zeros");
        check("zeros_coord", int'(held), 0);

        // Reset in the middle of a frame.
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        rst_n = 1'b0;
        m_k = 0;
        for (int i = 0; i < 6; i++) m_dig[i] = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        settle_and_check("post_reset_quiet");
        send_frame(8'h13, 8'h25, 8'h30, 8'h40, 8'h52, 8'h61);
        settle_and_check("post_reset");
        check("post_reset_ch0", int'(held[9:0]), 350);
        check("post_reset_ch1", int'(held[19:10]), 21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
